// File: rtl/ysyx_24090010_lsu.sv
// Load/store unit between execute and the data RAM: one operation in flight,
// func3 width/sign decode, optional alignment check, sign/zero-extended load return.
module ysyx_24090010_lsu #(
    parameter int MEM_WAIT    = 1,
    parameter bit CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_func3,
    input  logic        in_load,
    input  logic        in_store,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_strb,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  len_q, len_d;
    logic        sext_q, sext_d;
    logic        store_q, store_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [2:0]  dec_len;
    logic        dec_sext;
    logic        dec_bad;

    function automatic logic [31:0] mask_len(input logic [31:0] d, input logic [2:0] len);
        case (len)
            3'd1:    mask_len = {24'b0, d[7:0]};
            3'd2:    mask_len = {16'b0, d[15:0]};
            default: mask_len = d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] len, input logic sx);
        case (len)
            3'd1:    extend = sx ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
            3'd2:    extend = sx ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        dec_len  = 3'd0;
        dec_sext = 1'b0;
        dec_bad  = 1'b0;
        if (in_load && in_store) begin
            dec_bad = 1'b1;
        end else if (in_load) begin
            case (in_func3)
                3'b000:  begin dec_len = 3'd1; dec_sext = 1'b1; end
                3'b001:  begin dec_len = 3'd2; dec_sext = 1'b1; end
                3'b010:  dec_len = 3'd4;
                3'b100:  dec_len = 3'd1;
                3'b101:  dec_len = 3'd2;
                default: dec_bad = 1'b1;
            endcase
        end else if (in_store) begin
            case (in_func3)
                3'b000:  dec_len = 3'd1;
                3'b001:  dec_len = 3'd2;
                3'b010:  dec_len = 3'd4;
                default: dec_bad = 1'b1;
            endcase
        end
        if (CHECK_ALIGN && !dec_bad &&
            ((dec_len == 3'd2 && in_addr[0]) || (dec_len == 3'd4 && in_addr[1:0] != 2'b00)))
            dec_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            sext_q  <= 1'b0;
            store_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            sext_q  <= sext_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        sext_d  = sext_q;
        store_d = store_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    len_d   = dec_len;
                    sext_d  = dec_sext;
                    store_d = in_store && !in_load;
                    rdata_d = '0;
                    err_d   = dec_bad;
                    if (dec_bad || (!in_load && !in_store)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!store_q) rdata_d = extend(mem_rdata, len_q, sext_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_we is purely combinational from state so an async reset drops it at once
    always_comb begin
        in_ready  = rst && (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_rdata = rdata_q;
        out_err   = err_q;
        mem_addr  = '0;
        mem_strb  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr  = addr_q;
            mem_strb  = {29'b0, len_q};
            mem_wdata = store_q ? mask_len(wdata_q, len_q) : 32'b0;
            mem_we    = store_q && (cnt_q == 4'd0);
        end
    end

endmodule

// File: tb/tb_ysyx_24090010_lsu.sv
// Directed bench for the LSU: one instance with MEM_WAIT=1 and one with MEM_WAIT=3.
module tb_ysyx_24090010_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid1 = 1'b0, in_valid3 = 1'b0;
    logic [31:0] in_addr = '0, in_wdata = '0, mem_rdata = '0;
    logic [2:0]  in_func3 = '0;
    logic        in_load = 1'b0, in_store = 1'b0, out_ready = 1'b1;

    logic        in_ready1, out_valid1, out_err1, mem_we1;
    logic [31:0] out_rdata1, mem_addr1, mem_strb1, mem_wdata1;
    logic        in_ready3, out_valid3, out_err3, mem_we3;
    logic [31:0] out_rdata3, mem_addr3, mem_strb3, mem_wdata3;

    logic        sel = 1'b0;
    logic        i_ready, o_valid, o_err, m_we;
    logic [31:0] o_rdata, m_addr, m_strb, m_wdata;

    int n_tests = 0, n_fail = 0;
    int lat, acc_cyc, we_cyc, we_idx, we3_edges = 0, we3_before;
    logic [31:0] strb_seen, addr_seen, wdata_seen;

    always #5 clk = ~clk;

    ysyx_24090010_lsu #(.MEM_WAIT(1), .CHECK_ALIGN(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_func3(in_func3),
        .in_load(in_load), .in_store(in_store), .out_valid(out_valid1),
        .out_ready(out_ready), .out_rdata(out_rdata1), .out_err(out_err1),
        .mem_addr(mem_addr1), .mem_strb(mem_strb1), .mem_wdata(mem_wdata1),
        .mem_we(mem_we1), .mem_rdata(mem_rdata));

    ysyx_24090010_lsu #(.MEM_WAIT(3), .CHECK_ALIGN(1)) u_w3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_func3(in_func3),
        .in_load(in_load), .in_store(in_store), .out_valid(out_valid3),
        .out_ready(out_ready), .out_rdata(out_rdata3), .out_err(out_err3),
        .mem_addr(mem_addr3), .mem_strb(mem_strb3), .mem_wdata(mem_wdata3),
        .mem_we(mem_we3), .mem_rdata(mem_rdata));

    always_comb begin
        i_ready = sel ? in_ready3  : in_ready1;
        o_valid = sel ? out_valid3 : out_valid1;
        o_err   = sel ? out_err3   : out_err1;
        o_rdata = sel ? out_rdata3 : out_rdata1;
        m_we    = sel ? mem_we3    : mem_we1;
        m_addr  = sel ? mem_addr3  : mem_addr1;
        m_strb  = sel ? mem_strb3  : mem_strb1;
        m_wdata = sel ? mem_wdata3 : mem_wdata1;
    end

    always @(posedge clk) if (mem_we3) we3_edges <= we3_edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first negedge showing out_valid.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input logic ld, input logic st);
        sel = s; in_addr = a; in_wdata = wd; in_func3 = f3; in_load = ld; in_store = st;
        if (s) in_valid3 = 1'b1; else in_valid1 = 1'b1;
        #1 chk("in_ready_before_accept", {31'b0, i_ready}, 32'd1);
        @(posedge clk);
        lat = 1; acc_cyc = 0; we_cyc = 0; we_idx = -1;
        strb_seen = '0; addr_seen = '0; wdata_seen = '0;
        @(negedge clk);
        in_valid1 = 1'b0; in_valid3 = 1'b0;
        while (!o_valid && lat < 20) begin
            if (m_strb != 0) begin
                if (m_we) begin we_cyc++; we_idx = acc_cyc; end
                acc_cyc++;
                strb_seen = m_strb; addr_seen = m_addr; wdata_seen = m_wdata;
            end
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (!o_valid) chk("out_valid_timeout", {31'b0, o_valid}, 32'd1);
    endtask

    task automatic retire();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_in_ready1", {31'b0, in_ready1}, 32'd0);
        chk("rst_in_ready3", {31'b0, in_ready3}, 32'd0);
        chk("rst_out_valid", {30'b0, out_valid1, out_valid3}, 32'd0);
        chk("rst_mem_strb", mem_strb1 | mem_strb3, 32'd0);
        chk("rst_mem_we", {30'b0, mem_we1, mem_we3}, 32'd0);
        chk("rst_out_rdata", out_rdata1 | out_rdata3, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {30'b0, in_ready1, in_ready3}, 32'd3);

        // lb, sign-extended
        mem_rdata = 32'h0000_0080;
        run_op(1'b0, 32'h8000_0003, 32'h0, 3'b000, 1'b1, 1'b0);
        chk("lb_latency", lat, 2);
        chk("lb_access_cycles", acc_cyc, 1);
        chk("lb_strb", strb_seen, 32'd1);
        chk("lb_addr", addr_seen, 32'h8000_0003);
        chk("lb_we_cycles", we_cyc, 0);
        chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
        chk("lb_err", {31'b0, o_err}, 32'd0);
        retire();
        chk("lb_back_idle", {31'b0, i_ready}, 32'd1);

        // lhu, zero-extended
        mem_rdata = 32'hABCD_8001;
        run_op(1'b0, 32'h8000_0002, 32'h0, 3'b101, 1'b1, 1'b0);
        chk("lhu_strb", strb_seen, 32'd2);
        chk("lhu_rdata", o_rdata, 32'h0000_8001);
        retire();

        // lh, negative halfword
        mem_rdata = 32'h0000_F00F;
        run_op(1'b0, 32'h8000_0000, 32'h0, 3'b001, 1'b1, 1'b0);
        chk("lh_rdata", o_rdata, 32'hFFFF_F00F);
        retire();

        // lbu
        mem_rdata = 32'h1234_56FF;
        run_op(1'b0, 32'h8000_0001, 32'h0, 3'b100, 1'b1, 1'b0);
        chk("lbu_rdata", o_rdata, 32'h0000_00FF);
        retire();

        // sb masks write data to one byte
        run_op(1'b0, 32'h8000_0001, 32'h1234_5678, 3'b000, 1'b0, 1'b1);
        chk("sb_wdata", wdata_seen, 32'h0000_0078);
        chk("sb_we_cycles", we_cyc, 1);
        chk("sb_rdata", o_rdata, 32'd0);
        retire();

        // sw with MEM_WAIT=3
        we3_before = we3_edges;
        run_op(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1);
        chk("sw_latency", lat, 4);
        chk("sw_access_cycles", acc_cyc, 3);
        chk("sw_strb", strb_seen, 32'd4);
        chk("sw_addr", addr_seen, 32'h8000_0010);
        chk("sw_wdata", wdata_seen, 32'hDEAD_BEEF);
        chk("sw_we_cycles", we_cyc, 1);
        chk("sw_we_in_third", we_idx, 2);
        chk("sw_we_edges", we3_edges - we3_before, 1);
        chk("sw_rdata", o_rdata, 32'd0);
        chk("sw_err", {31'b0, o_err}, 32'd0);
        retire();

        // misaligned lw
        run_op(1'b0, 32'h8000_0002, 32'h0, 3'b010, 1'b1, 1'b0);
        chk("lw_mis_latency", lat, 1);
        chk("lw_mis_access", acc_cyc, 0);
        chk("lw_mis_err", {31'b0, o_err}, 32'd1);
        chk("lw_mis_rdata", o_rdata, 32'd0);
        retire();

        // undefined load func3
        mem_rdata = 32'h5555_5555;
        run_op(1'b0, 32'h8000_0000, 32'h0, 3'b011, 1'b1, 1'b0);
        chk("f3_011_latency", lat, 1);
        chk("f3_011_err", {31'b0, o_err}, 32'd1);
        chk("f3_011_rdata", o_rdata, 32'd0);
        retire();

        // misaligned sh, undefined store func3, load+store, no-op
        run_op(1'b1, 32'h8000_0001, 32'h0, 3'b001, 1'b0, 1'b1);
        chk("sh_mis_err", {31'b0, o_err}, 32'd1);
        chk("sh_mis_access", acc_cyc, 0);
        retire();
        run_op(1'b1, 32'h8000_0000, 32'h0, 3'b100, 1'b0, 1'b1);
        chk("store_f3_100_err", {31'b0, o_err}, 32'd1);
        retire();
        run_op(1'b0, 32'h8000_0000, 32'h0, 3'b010, 1'b1, 1'b1);
        chk("ld_st_both_err", {31'b0, o_err}, 32'd1);
        retire();
        run_op(1'b1, 32'hFFFF_FFFF, 32'h0, 3'b000, 1'b0, 1'b0);
        chk("noop_latency", lat, 1);
        chk("noop_err", {31'b0, o_err}, 32'd0);
        chk("noop_rdata", o_rdata, 32'd0);
        retire();

        // byte load at top of address space passes address through
        mem_rdata = 32'h0000_007F;
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0, 3'b000, 1'b1, 1'b0);
        chk("top_addr", addr_seen, 32'hFFFF_FFFF);
        chk("top_rdata", o_rdata, 32'h0000_007F);
        retire();

        // backpressure
        out_ready = 1'b0;
        mem_rdata = 32'h1234_5678;
        run_op(1'b0, 32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0);
        chk("bp_rdata", o_rdata, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, o_valid}, 32'd1);
            chk("bp_hold_rdata", o_rdata, 32'h1234_5678);
            chk("bp_hold_in_ready", {31'b0, i_ready}, 32'd0);
        end
        out_ready = 1'b1;
        retire();
        chk("bp_release_in_ready", {31'b0, i_ready}, 32'd1);
        chk("bp_release_valid", {31'b0, o_valid}, 32'd0);

        // reset in second ACCESS cycle of an sw (MEM_WAIT=3)
        sel = 1'b1;
        we3_before = we3_edges;
        in_addr = 32'h8000_0020; in_wdata = 32'hCAFE_F00D; in_func3 = 3'b010;
        in_load = 1'b0; in_store = 1'b1; in_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("rst_sw_c1_strb", m_strb, 32'd4);
        chk("rst_sw_c1_we", {31'b0, m_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_sw_c2_we", {31'b0, m_we}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_strb", m_strb, 32'd0);
        chk("rst_mid_addr", m_addr, 32'd0);
        chk("rst_mid_wdata", m_wdata, 32'd0);
        chk("rst_mid_we", {31'b0, m_we}, 32'd0);
        chk("rst_mid_in_ready", {31'b0, i_ready}, 32'd0);
        chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
        retire();
        retire();
        rst = 1'b1;
        retire();
        chk("rst_after_in_ready", {31'b0, i_ready}, 32'd1);
        chk("rst_after_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_no_write", we3_edges - we3_before, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
